// File: rtl/spi_master_frame_sequencer.sv
// Feeds SPI_FPGA_MASTER one frame per buffered TX word and collects each received word
// into an RX FIFO, with an enforced CS-high gap between frames and a launch-to-done timeout.
module spi_master_frame_sequencer #(
    parameter int PACK_LENGTH  = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int GAP_CLKS     = 4,
    parameter int TIMEOUT_CLKS = 1024
) (
    input  logic                   IN_CLOCK,
    input  logic                   IN_RESET_N,
    input  logic [PACK_LENGTH-1:0] IN_TX_DATA,
    input  logic                   IN_TX_VALID,
    output logic                   OUT_TX_READY,
    output logic [PACK_LENGTH-1:0] OUT_RX_DATA,
    output logic                   OUT_RX_VALID,
    input  logic                   IN_RX_READY,
    output logic                   OUT_LAUNCH,
    output logic [PACK_LENGTH-1:0] OUT_MASTER_DATA,
    input  logic                   IN_MASTER_CS,
    input  logic [PACK_LENGTH-1:0] IN_MASTER_RECEIVE_DATA,
    input  logic                   IN_MASTER_ACTION_DONE,
    output logic                   OUT_BUSY,
    output logic                   OUT_TIMEOUT_ERR,
    input  logic                   IN_CLEAR_ERR
);
    // state  | meaning
    // IDLE   | waiting for a TX word and a free RX slot
    // LAUNCH | OUT_LAUNCH high until the master pulls CS low
    // ACTIVE | frame in progress, waiting for the done rising edge
    // GAP    | CS-high spacing before the next frame
    typedef enum logic [1:0] {IDLE, LAUNCH, ACTIVE, GAP} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CLKS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);

    state_t state, state_next;

    logic [PACK_LENGTH-1:0] tx_mem [FIFO_DEPTH];
    logic [PACK_LENGTH-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0]            tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic                   tx_empty, tx_full, tx_push, tx_pop;
    logic                   rx_empty, rx_full, rx_push, rx_pop;
    logic [TW-1:0]          to_cnt;
    logic [GW-1:0]          gap_cnt;
    logic                   done_prev, done_rise, timeout_hit, abort;
    logic                   timeout_err;
    logic [PACK_LENGTH-1:0] master_data;

    assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full  = (tx_wr_ptr[AW] != tx_rd_ptr[AW]) && (tx_wr_ptr[AW-1:0] == tx_rd_ptr[AW-1:0]);
    assign tx_push  = IN_TX_VALID && !tx_full;

    assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
    assign rx_full  = (rx_wr_ptr[AW] != rx_rd_ptr[AW]) && (rx_wr_ptr[AW-1:0] == rx_rd_ptr[AW-1:0]);
    assign rx_pop   = !rx_empty && IN_RX_READY;

    assign done_rise   = IN_MASTER_ACTION_DONE && !done_prev;
    assign timeout_hit = (to_cnt == TO_LAST);

    always_ff @(posedge IN_CLOCK) begin
        if (!IN_RESET_N) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
        end else begin
            if (tx_push) begin
                tx_mem[tx_wr_ptr[AW-1:0]] <= IN_TX_DATA;
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            end
            if (tx_pop) tx_rd_ptr <= tx_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge IN_CLOCK) begin
        if (!IN_RESET_N) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wr_ptr[AW-1:0]] <= IN_MASTER_RECEIVE_DATA;
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            end
            if (rx_pop) rx_rd_ptr <= rx_rd_ptr + 1'b1;
        end
    end

    // A frame only starts with a free RX slot, so rx_push can never hit a full FIFO.
    always_comb begin
        state_next = state;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_empty && !rx_full) begin
                    tx_pop     = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                if (!IN_MASTER_CS) begin
                    state_next = ACTIVE;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = GAP;
                end
            end
            ACTIVE: begin
                if (done_rise) begin
                    rx_push    = 1'b1;
                    state_next = GAP;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge IN_CLOCK) begin
        if (!IN_RESET_N) begin
            state       <= IDLE;
            to_cnt      <= '0;
            gap_cnt     <= '0;
            done_prev   <= 1'b0;
            timeout_err <= 1'b0;
            master_data <= '0;
        end else begin
            state     <= state_next;
            done_prev <= IN_MASTER_ACTION_DONE;
            if (tx_pop) begin
                master_data <= tx_mem[tx_rd_ptr[AW-1:0]];
                to_cnt      <= '0;
            end else if (state == LAUNCH || state == ACTIVE) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (state_next == GAP && state != GAP) begin
                gap_cnt <= GAP_LAST;
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            if (abort) begin
                timeout_err <= 1'b1;
            end else if (IN_CLEAR_ERR) begin
                timeout_err <= 1'b0;
            end
        end
    end

    assign OUT_TX_READY    = !tx_full;
    assign OUT_RX_VALID    = !rx_empty;
    assign OUT_RX_DATA     = rx_empty ? '0 : rx_mem[rx_rd_ptr[AW-1:0]];
    assign OUT_LAUNCH      = (state == LAUNCH);
    assign OUT_BUSY        = (state != IDLE);
    assign OUT_MASTER_DATA = master_data;
    assign OUT_TIMEOUT_ERR = timeout_err;

endmodule
